// File: rtl/fp_sum_sequencer_pkg.sv
// fp_sum_sequencer_pkg: float32 constants and FSM state encodings shared by the sum sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fp_sum_sequencer_pkg;

   // float32 bit patterns
   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE      = 32'h3F80_0000;

   // 2-bit sequencer states
   localparam logic [1:0] ST_GET    = 2'd0;
   localparam logic [1:0] ST_SEND   = 2'd1;
   localparam logic [1:0] ST_WAIT_Z = 2'd2;
   localparam logic [1:0] ST_OUT    = 2'd3;

endpackage

// File: rtl/fp_sum_sequencer.sv
// fp_sum_sequencer: feeds a stream of float32 values through an external adder, one result per LEN inputs.
// Latency: per element 1 cycle to adder a/b stb + adder latency + 1 cycle; sum_stb after the LEN-th element.
// Backpressure: in_ack only while idle in GET; a slow adder or a held-off sum_ack stalls upstream.
//
// Ports:
//   clk, rst                       clock and async active-low reset
//   in_data/in_stb/in_ack          float32 operand stream from upstream
//   adder_a/_stb/_ack              running accumulator to adder input_a
//   adder_b/_stb/_ack              latched operand to adder input_b
//   adder_z/_stb/_ack              adder result back into the accumulator
//   sum/sum_stb/sum_ack            accumulated result to downstream
//   busy                           low only when idle between batches
module fp_sum_sequencer
   import fp_sum_sequencer_pkg::*;
#(
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_stb,
   output logic        in_ack,
   output logic [31:0] adder_a,
   output logic        adder_a_stb,
   input  logic        adder_a_ack,
   output logic [31:0] adder_b,
   output logic        adder_b_stb,
   input  logic        adder_b_ack,
   input  logic [31:0] adder_z,
   input  logic        adder_z_stb,
   output logic        adder_z_ack,
   output logic [31:0] sum,
   output logic        sum_stb,
   input  logic        sum_ack,
   output logic        busy
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

   logic [1:0]       state;
   logic [31:0]      acc;
   logic [CNT_W-1:0] cnt;
   logic             run;     // low while in reset and for the first edge after release
   logic             a_done;
   logic             b_done;

   // A side is finished once its stb is already low or transfers on this edge.
   assign a_done = !adder_a_stb || adder_a_ack;
   assign b_done = !adder_b_stb || adder_b_ack;

   // in_ack is held off while reset is asserted so upstream cannot see a ready
   // block before the first clock after release.
   assign in_ack      = run && (state == ST_GET);
   assign adder_z_ack = (state == ST_WAIT_Z);
   assign busy        = !((state == ST_GET) && (cnt == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_GET;
         acc         <= FP_POS_ZERO;
         cnt         <= '0;
         run         <= 1'b0;
         adder_a     <= FP_POS_ZERO;
         adder_b     <= FP_POS_ZERO;
         adder_a_stb <= 1'b0;
         adder_b_stb <= 1'b0;
         sum         <= FP_POS_ZERO;
         sum_stb     <= 1'b0;
      end else begin
         run <= 1'b1;
         case (state)
            ST_GET: begin
               if (in_stb && in_ack) begin
                  adder_b     <= in_data;
                  adder_a     <= acc;
                  adder_a_stb <= 1'b1;
                  adder_b_stb <= 1'b1;
                  state       <= ST_SEND;
               end
            end
            ST_SEND: begin
               // Each side clears independently; leave once both are done.
               if (adder_a_stb && adder_a_ack) adder_a_stb <= 1'b0;
               if (adder_b_stb && adder_b_ack) adder_b_stb <= 1'b0;
               if (a_done && b_done) state <= ST_WAIT_Z;
            end
            ST_WAIT_Z: begin
               if (adder_z_stb) begin
                  acc <= adder_z;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_IDX) begin
                     sum     <= adder_z;
                     sum_stb <= 1'b1;
                     state   <= ST_OUT;
                  end else begin
                     state <= ST_GET;
                  end
               end
            end
            ST_OUT: begin
               if (sum_ack) begin
                  sum_stb <= 1'b0;
                  acc     <= FP_POS_ZERO;
                  cnt     <= '0;
                  state   <= ST_GET;
               end
            end
            default: state <= ST_GET;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// tb_fp_sum_sequencer: two sequencers (LEN=4 and LEN=1), each paired with a behavioural stb/ack float adder.
// Latency: n/a (bench).
// Backpressure: adder ack delays and sum_ack hold-off are varied per test.
module tb_fp_sum_sequencer;

   localparam int TMO = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [31:0] in_data[2], adder_a[2], adder_b[2], adder_z[2], sum[2];
   logic        in_stb[2], in_ack[2], a_stb[2], a_ack[2], b_stb[2], b_ack[2];
   logic        z_stb[2], z_ack[2], sum_stb[2], sum_ack[2], busy[2];

   fp_sum_sequencer #(.LEN(4), .CNT_W(8)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_data(in_data[0]), .in_stb(in_stb[0]), .in_ack(in_ack[0]),
      .adder_a(adder_a[0]), .adder_a_stb(a_stb[0]), .adder_a_ack(a_ack[0]),
      .adder_b(adder_b[0]), .adder_b_stb(b_stb[0]), .adder_b_ack(b_ack[0]),
      .adder_z(adder_z[0]), .adder_z_stb(z_stb[0]), .adder_z_ack(z_ack[0]),
      .sum(sum[0]), .sum_stb(sum_stb[0]), .sum_ack(sum_ack[0]), .busy(busy[0]));

   fp_sum_sequencer #(.LEN(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_data(in_data[1]), .in_stb(in_stb[1]), .in_ack(in_ack[1]),
      .adder_a(adder_a[1]), .adder_a_stb(a_stb[1]), .adder_a_ack(a_ack[1]),
      .adder_b(adder_b[1]), .adder_b_stb(b_stb[1]), .adder_b_ack(b_ack[1]),
      .adder_z(adder_z[1]), .adder_z_stb(z_stb[1]), .adder_z_ack(z_ack[1]),
      .sum(sum[1]), .sum_stb(sum_stb[1]), .sum_ack(sum_ack[1]), .busy(busy[1]));

   // ---------------- float helpers (normal numbers and zero only) ----------------
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      logic [10:0] e;
      if (f[30:23] == 8'h00) return 0.0;
      e = 11'(int'(f[30:23]) - 127 + 1023);
      d = {f[31], e, f[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'b0};
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if (a[30:23] == 8'hFF) return a;
      if (b[30:23] == 8'hFF) return b;
      return r2f(f2r(a) + f2r(b));
   endfunction

   // ---------------- behavioural adder partner, one per DUT ----------------
   int          a_dly[2], b_dly[2], lat[2];
   int          a_cnt[2], b_cnt[2], l_cnt[2];
   logic [31:0] ra[2], rb[2];
   logic        a_got[2], b_got[2];

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            a_ack[i] <= 1'b0; b_ack[i] <= 1'b0; z_stb[i] <= 1'b0; adder_z[i] <= 32'h0;
            a_got[i] <= 1'b0; b_got[i] <= 1'b0;
            a_cnt[i] <= 0; b_cnt[i] <= 0; l_cnt[i] <= 0;
            ra[i] <= 32'h0; rb[i] <= 32'h0;
         end else begin
            if (a_stb[i] && !a_got[i]) begin
               if (a_ack[i]) begin a_got[i] <= 1'b1; a_ack[i] <= 1'b0; ra[i] <= adder_a[i]; end
               else if (a_cnt[i] >= a_dly[i]) a_ack[i] <= 1'b1;
               else a_cnt[i] <= a_cnt[i] + 1;
            end
            if (b_stb[i] && !b_got[i]) begin
               if (b_ack[i]) begin b_got[i] <= 1'b1; b_ack[i] <= 1'b0; rb[i] <= adder_b[i]; end
               else if (b_cnt[i] >= b_dly[i]) b_ack[i] <= 1'b1;
               else b_cnt[i] <= b_cnt[i] + 1;
            end
            if (a_got[i] && b_got[i] && !z_stb[i]) begin
               if (l_cnt[i] >= lat[i]) begin z_stb[i] <= 1'b1; adder_z[i] <= fadd(ra[i], rb[i]); end
               else l_cnt[i] <= l_cnt[i] + 1;
            end
            if (z_stb[i] && z_ack[i]) begin
               z_stb[i] <= 1'b0; a_got[i] <= 1'b0; b_got[i] <= 1'b0;
               a_cnt[i] <= 0; b_cnt[i] <= 0; l_cnt[i] <= 0;
            end
         end
      end
   end

   // ---------------- protocol monitor ----------------
   int proto_err = 0;
   bit a_first_seen = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            if (z_ack[i] && (a_stb[i] || b_stb[i])) proto_err++;
            if (in_ack[i] && (a_stb[i] || b_stb[i] || z_ack[i] || sum_stb[i])) proto_err++;
         end
         if (!a_stb[0] && b_stb[0]) a_first_seen = 1'b1;
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [31:0] d);
      int c = 0;
      @(negedge clk);
      in_data[i] = d;
      in_stb[i]  = 1'b1;
      while (!in_ack[i] && c < TMO) begin @(negedge clk); c++; end
      chk("in_accept", {31'b0, in_ack[i]}, 32'd1);
      @(posedge clk);
      #1;
      in_stb[i] = 1'b0;
   endtask

   // Waits for sum_stb, optionally holds sum_ack low for 'hold' cycles, then acknowledges.
   task automatic collect(input int i, input int hold, output logic [31:0] d);
      int c = 0;
      int herr = 0;
      @(negedge clk);
      while (!sum_stb[i] && c < TMO) begin @(negedge clk); c++; end
      chk("sum_stb_seen", {31'b0, sum_stb[i]}, 32'd1);
      chk("busy_in_out", {31'b0, busy[i]}, 32'd1);
      d = sum[i];
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (sum[i] !== d || !sum_stb[i] || in_ack[i]) herr++;
      end
      if (hold > 0) chk("sum_hold_stable", herr, 0);
      sum_ack[i] = 1'b1;
      @(posedge clk);
      #1;
      sum_ack[i] = 1'b0;
   endtask

   typedef struct {
      logic [3:0][31:0] v;
      logic [31:0]      exp;
      int               ad, bd, l;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] x0, x1, x2, x3, input logic [31:0] e,
                               input int ad, input int bd, input int l);
      vec_t t;
      t.v[0] = x0; t.v[1] = x1; t.v[2] = x2; t.v[3] = x3;
      t.exp = e; t.ad = ad; t.bd = bd; t.l = l;
      return t;
   endfunction

   vec_t        tbl[5];
   logic [31:0] got;
   int          s, x;

   initial begin
      tbl[0] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, 0, 0, 0);
      tbl[1] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, 0, 3, 2);
      tbl[2] = mk(32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3E000000, 32'h3F800000, 2, 1, 1);
      tbl[3] = mk(32'h41200000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'h40E00000, 1, 1, 0);
      tbl[4] = mk(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000, 32'h00000000, 3, 0, 4);

      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_data[i] = 32'h0; in_stb[i] = 1'b0; sum_ack[i] = 1'b0;
         a_dly[i] = 0; b_dly[i] = 0; lat[i] = 1;
      end

      // Reset held for 5 clocks: everything idle, in_ack low too.
      repeat (5) @(negedge clk);
      chk("rst_in_ack", {31'b0, in_ack[0]}, 32'd0);
      chk("rst_a_stb", {31'b0, a_stb[0]}, 32'd0);
      chk("rst_b_stb", {31'b0, b_stb[0]}, 32'd0);
      chk("rst_z_ack", {31'b0, z_ack[0]}, 32'd0);
      chk("rst_sum_stb", {31'b0, sum_stb[0]}, 32'd0);
      chk("rst_busy", {31'b0, busy[0]}, 32'd0);
      chk("rst_sum", sum[0], 32'h0);
      chk("rst_adder_a", adder_a[0], 32'h0);
      chk("rst_adder_b", adder_b[0], 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_in_ack", {31'b0, in_ack[0]}, 32'd1);
      chk("post_rst_busy", {31'b0, busy[0]}, 32'd0);

      // Table of LEN=4 batches with varied adder ack/latency timing.
      for (int k = 0; k < 5; k++) begin
         a_dly[0] = tbl[k].ad; b_dly[0] = tbl[k].bd; lat[0] = tbl[k].l;
         a_first_seen = 1'b0;
         for (int j = 0; j < 4; j++) push(0, tbl[k].v[j]);
         collect(0, (k == 0) ? 3 : 0, got);
         chk($sformatf("vec%0d_sum", k), got, tbl[k].exp);
         if (k == 1) chk("a_stb_drops_first", {31'b0, a_first_seen}, 32'd1);
      end
      @(negedge clk);
      chk("idle_busy", {31'b0, busy[0]}, 32'd0);

      // Downstream stalls 20 clocks while upstream already offers the next value.
      a_dly[0] = 0; b_dly[0] = 0; lat[0] = 1;
      for (int j = 1; j <= 4; j++) push(0, r2f(real'(j)));
      @(negedge clk);
      in_data[0] = 32'h40A00000;
      in_stb[0]  = 1'b1;
      collect(0, 20, got);
      chk("stall_sum", got, 32'h41200000);
      push(0, 32'h40A00000);
      push(0, 32'h40C00000);
      push(0, 32'h40E00000);
      push(0, 32'h41000000);
      collect(0, 0, got);
      chk("after_stall_sum", got, 32'h41D00000);

      // Reset while waiting on the third adder result; partial sum must vanish.
      lat[0] = 6;
      push(0, 32'h3F800000);
      push(0, 32'h40000000);
      push(0, 32'h40400000);
      begin
         int c = 0;
         while (!z_ack[0] && c < TMO) begin @(negedge clk); c++; end
         chk("reached_wait_z", {31'b0, z_ack[0]}, 32'd1);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'b0, busy[0]}, 32'd0);
      chk("midrst_z_ack", {31'b0, z_ack[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      lat[0] = 1;
      push(0, 32'h40000000);
      push(0, 32'hC0000000);
      push(0, 32'h40000000);
      push(0, 32'hC0000000);
      collect(0, 0, got);
      chk("after_midrst_sum", got, 32'h00000000);

      // LEN=1: each value comes back as +0.0 + x, NaN passes through.
      push(1, 32'h40400000);
      collect(1, 0, got);
      chk("len1_three", got, 32'h40400000);
      push(1, 32'h7FC00000);
      collect(1, 0, got);
      chk("len1_nan", {31'b0, (got[30:23] == 8'hFF) && (got[22:0] != 23'd0)}, 32'd1);

      // Randomized LEN=4 batches of small integers; reference is the plain integer sum.
      for (int n = 0; n < 25; n++) begin
         a_dly[0] = $urandom_range(0, 3);
         b_dly[0] = $urandom_range(0, 3);
         lat[0]   = $urandom_range(0, 3);
         s = 0;
         for (int j = 0; j < 4; j++) begin
            x = int'($urandom_range(0, 100)) - 50;
            s += x;
            push(0, r2f(real'(x)));
         end
         collect(0, $urandom_range(0, 3), got);
         chk($sformatf("rand%0d_sum", n), got, r2f(real'(s)));
      end
      for (int n = 0; n < 5; n++) begin
         lat[1] = $urandom_range(0, 2);
         x = int'($urandom_range(0, 200)) - 100;
         push(1, r2f(real'(x)));
         collect(1, 0, got);
         chk($sformatf("rand_len1_%0d", n), got, r2f(real'(x)));
      end

      chk("protocol_violations", proto_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
